// File: rtl/l2_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate L2 cache controller with one 64-bit line per set.
// Lines are filled and written back over a strobe-acknowledged memory port; hits and misses are counted.
module l2_cache_ctrl #(
   parameter int INDEX_BITS = 4,
   parameter int CNT_BITS   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                addrstb,
   input  logic [31:0]         addr,
   input  logic                we,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   output logic                stall,
   output logic                done,
   output logic                memreq,
   output logic                memwe,
   output logic [31:0]         memaddr,
   output logic [63:0]         memwdata,
   input  logic [63:0]         memrdata,
   input  logic                stb,
   output logic [CNT_BITS-1:0] hitcnt,
   output logic [CNT_BITS-1:0] misscnt
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 29 - INDEX_BITS;

   typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_FILL, S_DONE} state_t;

   state_t                r_state, w_next;
   logic [31:2]           r_addr;
   logic                  r_we;
   logic [31:0]           r_wdata;
   logic                  r_first;
   logic [63:0]           r_data [LINES];
   logic [TAG_BITS-1:0]   r_tag  [LINES];
   logic [LINES-1:0]      r_valid, r_dirty;
   logic [31:0]           r_rdata;
   logic                  r_memreq, r_memwe;
   logic [31:0]           r_memaddr;
   logic [63:0]           r_memwdata;
   logic [CNT_BITS-1:0]   r_hitcnt, r_misscnt;

   logic [INDEX_BITS-1:0] w_idx;
   logic [TAG_BITS-1:0]   w_req_tag;
   logic                  w_hit, w_victim_dirty, w_fill_ack, w_write_hit;
   logic                  w_unused;

   assign w_idx          = r_addr[2+INDEX_BITS:3];
   assign w_req_tag      = r_addr[31:3+INDEX_BITS];
   assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_req_tag);
   assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
   // memreq is high exactly while in WRITEBACK/FILL, so gating on state drops stray strobes
   assign w_fill_ack     = (r_state == S_FILL) && stb;
   assign w_write_hit    = (r_state == S_COMPARE) && w_hit && r_we;
   assign w_unused       = ^addr[1:0];

   // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // NOTE: every always_comb output is given a default first so no latch can be inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (addrstb) w_next = S_COMPARE;
         S_COMPARE:   if (w_hit)                w_next = S_DONE;
                      else if (w_victim_dirty)  w_next = S_WRITEBACK;
                      else                      w_next = S_FILL;
         S_WRITEBACK: if (stb) w_next = S_FILL;
         S_FILL:      if (stb) w_next = S_COMPARE;
         S_DONE:      w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      case (r_state)
         S_COMPARE, S_WRITEBACK, S_FILL: stall = 1'b1;
         S_DONE:                         done  = 1'b1;
         default: ;
      endcase
   end

   // The post-fill COMPARE must not be counted, so only the first COMPARE of a request counts
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && addrstb) begin
         r_addr  <= addr[31:2];
         r_we    <= we;
         r_wdata <= wdata;
         r_first <= 1'b1;
      end else if (r_state == S_COMPARE) begin
         r_first <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (w_fill_ack) begin
         r_valid[w_idx] <= 1'b1;
         r_dirty[w_idx] <= 1'b0;
      end else if (w_write_hit) begin
         r_dirty[w_idx] <= 1'b1;
      end
   end

   // NOTE: data and tag arrays carry no reset; the valid bits make their contents irrelevant after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_fill_ack) begin
            r_data[w_idx] <= memrdata;
            r_tag[w_idx]  <= w_req_tag;
         end else if (w_write_hit) begin
            if (r_addr[2]) r_data[w_idx][63:32] <= r_wdata;
            else           r_data[w_idx][31:0]  <= r_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata   <= '0;
         r_hitcnt  <= '0;
         r_misscnt <= '0;
      end else if (r_state == S_COMPARE) begin
         if (w_hit && !r_we)
            r_rdata <= r_addr[2] ? r_data[w_idx][63:32] : r_data[w_idx][31:0];
         if (r_first && w_hit && !(&r_hitcnt))
            r_hitcnt <= r_hitcnt + 1'b1;
         if (r_first && !w_hit && !(&r_misscnt))
            r_misscnt <= r_misscnt + 1'b1;
      end
   end

   // Memory port is registered from the next state; address and data only change when a transfer starts
   always_ff @(posedge clk) begin
      if (reset) begin
         r_memreq   <= 1'b0;
         r_memwe    <= 1'b0;
         r_memaddr  <= '0;
         r_memwdata <= '0;
      end else begin
         r_memreq <= (w_next == S_WRITEBACK) || (w_next == S_FILL);
         if (r_state == S_COMPARE && w_next == S_WRITEBACK) begin
            r_memwe    <= 1'b1;
            r_memaddr  <= {r_tag[w_idx], w_idx, 3'b000};
            r_memwdata <= r_data[w_idx];
         end else if (w_next == S_FILL && r_state != S_FILL) begin
            r_memwe    <= 1'b0;
            r_memaddr  <= {w_req_tag, w_idx, 3'b000};
         end
      end
   end

   assign rdata    = r_rdata;
   assign memreq   = r_memreq;
   assign memwe    = r_memwe;
   assign memaddr  = r_memaddr;
   assign memwdata = r_memwdata;
   assign hitcnt   = r_hitcnt;
   assign misscnt  = r_misscnt;

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Scoreboard bench for l2_cache_ctrl: expected read data and memory transfers are queued when a
// request is issued and compared when the DUT completes or raises memreq.
module tb_l2_cache_ctrl;
   localparam int INDEX_BITS = 4;
   localparam int CNT_W      = 3;
   localparam int MAXC       = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset, addrstb, we, stb;
   logic [31:0]       addr, wdata, rdata, memaddr;
   logic              stall, done, memreq, memwe;
   logic [63:0]       memwdata, memrdata;
   logic [CNT_W-1:0]  hitcnt, misscnt;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [63:0] wdata;
   } xfer_t;

   xfer_t        xfer_q[$];
   logic [31:0]  rd_q[$];
   logic [63:0]  mem [logic [31:0]];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           exp_hit  = 0;
   int           exp_miss = 0;
   logic [31:0]  last_rd  = '0;

   l2_cache_ctrl #(.INDEX_BITS(INDEX_BITS), .CNT_BITS(CNT_W)) dut (
      .clk(clk), .reset(reset), .addrstb(addrstb), .addr(addr), .we(we), .wdata(wdata),
      .rdata(rdata), .stall(stall), .done(done), .memreq(memreq), .memwe(memwe),
      .memaddr(memaddr), .memwdata(memwdata), .memrdata(memrdata), .stb(stb),
      .hitcnt(hitcnt), .misscnt(misscnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v == MAXC) ? MAXC : v + 1;
   endfunction

   function automatic logic [63:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 64'h0;
   endfunction

   task automatic push_xfer(input logic w, input logic [31:0] a, input logic [63:0] d);
      xfer_t x;
      x.we = w; x.addr = a; x.wdata = d;
      xfer_q.push_back(x);
   endtask

   // Issue one request and service memory until done; poke pulses a stray addrstb during a stall
   task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit is_hit, input int delay, input bit poke);
      int          n, wait_c;
      bit          in_xfer, got_done;
      xfer_t       x;
      logic [31:0] snap_addr;
      logic [63:0] snap_wdata;
      logic        snap_we;
      rd_q.push_back(w ? last_rd : exp_rd);
      addrstb = 1'b1; addr = a; we = w; wdata = wd;
      @(posedge clk); #1;
      addrstb = 1'b0; addr = 32'hFFFF_FFF8; we = ~w; wdata = 32'h0;
      n = 1; wait_c = 0; in_xfer = 1'b0; got_done = 1'b0;
      snap_addr = '0; snap_wdata = '0; snap_we = 1'b0;
      while (!got_done && n < 200) begin
         stb = 1'b0; addrstb = 1'b0;
         if (memreq) begin
            if (!in_xfer) begin
               in_xfer = 1'b1; wait_c = 0;
               snap_addr = memaddr; snap_wdata = memwdata; snap_we = memwe;
               if (xfer_q.size() == 0) begin
                  check("unexpected_xfer", {32'h0, memaddr}, 64'hFFFF_FFFF);
               end else begin
                  x = xfer_q.pop_front();
                  check("xfer_we", memwe, x.we);
                  check("xfer_addr", memaddr, x.addr);
                  if (x.we) check("wb_data", memwdata, x.wdata);
               end
            end else begin
               check("hold_addr", memaddr, snap_addr);
               check("hold_wdata", memwdata, snap_wdata);
               check("hold_we", memwe, snap_we);
               check("hold_stall", stall, 1'b1);
            end
            if (wait_c == delay) begin
               stb = 1'b1;
               memrdata = mem_rd(memaddr);
               if (memwe) mem[memaddr] = memwdata;
               in_xfer = 1'b0;
            end else begin
               wait_c++;
               if (poke && wait_c == 1) begin
                  addrstb = 1'b1; addr = 32'h0000_0BB0; we = 1'b1; wdata = 32'hBAD0_BAD0;
               end
            end
         end
         if (done) begin
            got_done = 1'b1;
            check("rdata", rdata, rd_q.pop_front());
         end else begin
            @(posedge clk); #1;
            n++;
         end
      end
      stb = 1'b0; addrstb = 1'b0;
      if (!got_done) check("done_timeout", n, 0);
      if (is_hit) begin
         check("hit_latency", n, 2);
         exp_hit = sat_inc(exp_hit);
      end else begin
         exp_miss = sat_inc(exp_miss);
      end
      if (!w) last_rd = exp_rd;
      check("xfers_pending", xfer_q.size(), 0);
      check("hitcnt", hitcnt, exp_hit);
      check("misscnt", misscnt, exp_miss);
      @(posedge clk); #1;
      check("idle_stall", stall, 1'b0);
      check("done_pulse", done, 1'b0);
   endtask

   // Reset two cycles into a fill, with addrstb and stb raised in the same cycle
   task automatic abort_fill(input logic [31:0] a);
      int k;
      addrstb = 1'b1; addr = a; we = 1'b0;
      @(posedge clk); #1;
      addrstb = 1'b0;
      k = 0;
      while (!memreq && k < 50) begin @(posedge clk); #1; k++; end
      check("abort_reach_fill", memreq, 1'b1);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1; addrstb = 1'b1; stb = 1'b1; memrdata = '1;
      @(posedge clk); #1;
      reset = 1'b0; addrstb = 1'b0; stb = 1'b0;
      check("abort_memreq", memreq, 1'b0);
      check("abort_stall", stall, 1'b0);
      check("abort_memaddr", memaddr, 32'h0);
      check("abort_rdata", rdata, 32'h0);
      check("abort_hitcnt", hitcnt, 0);
      check("abort_misscnt", misscnt, 0);
      exp_hit = 0; exp_miss = 0; last_rd = '0;
      @(posedge clk); #1;
      check("abort_idle", stall, 1'b0);
   endtask

   task automatic stb_in_idle();
      stb = 1'b1; memrdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk); #1;
      stb = 1'b0;
      check("idle_stb_memreq", memreq, 1'b0);
      check("idle_stb_stall", stall, 1'b0);
      check("idle_stb_hitcnt", hitcnt, exp_hit);
      check("idle_stb_misscnt", misscnt, exp_miss);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mem[32'h0000_0040] = 64'h1111_2222_3333_4444;
      mem[32'h0000_0840] = 64'hAAAA_BBBB_CCCC_DDDD;
      mem[32'h0000_1048] = 64'h5555_6666_7777_8888;
      mem[32'h0000_2048] = 64'h9999_0000_1234_ABCD;
      mem[32'h0000_3000] = 64'h0BAD_F00D_C0DE_CAFE;
      reset = 1'b1; addrstb = 1'b0; addr = '0; we = 1'b0; wdata = '0; stb = 1'b0; memrdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", stall, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_memreq", memreq, 1'b0);
      check("rst_memwe", memwe, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_memaddr", memaddr, 32'h0);
      check("rst_memwdata", memwdata, 64'h0);
      check("rst_hitcnt", hitcnt, 0);
      check("rst_misscnt", misscnt, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      push_xfer(1'b0, 32'h0000_0040, '0);
      do_req(32'h0000_0040, 1'b0, '0, 32'h3333_4444, 1'b0, 1, 1'b0);
      do_req(32'h0000_0044, 1'b0, '0, 32'h1111_2222, 1'b1, 0, 1'b0);
      do_req(32'h0000_0044, 1'b1, 32'hDEAD_BEEF, '0, 1'b1, 0, 1'b0);

      push_xfer(1'b1, 32'h0000_0040, 64'hDEAD_BEEF_3333_4444);
      push_xfer(1'b0, 32'h0000_0840, '0);
      do_req(32'h0000_0840, 1'b0, '0, 32'hCCCC_DDDD, 1'b0, 5, 1'b1);

      stb_in_idle();

      push_xfer(1'b0, 32'h0000_0040, '0);
      do_req(32'h0000_0044, 1'b0, '0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);

      push_xfer(1'b0, 32'h0000_1048, '0);
      do_req(32'h0000_1048, 1'b1, 32'h1234_5678, '0, 1'b0, 2, 1'b0);
      do_req(32'h0000_1048, 1'b0, '0, 32'h1234_5678, 1'b1, 0, 1'b0);
      push_xfer(1'b1, 32'h0000_1048, 64'h5555_6666_1234_5678);
      push_xfer(1'b0, 32'h0000_2048, '0);
      do_req(32'h0000_204C, 1'b0, '0, 32'h9999_0000, 1'b0, 1, 1'b0);

      abort_fill(32'h0000_3000);
      push_xfer(1'b0, 32'h0000_3000, '0);
      do_req(32'h0000_3000, 1'b0, '0, 32'hC0DE_CAFE, 1'b0, 3, 1'b0);
      for (int i = 0; i < MAXC + 1; i++)
         do_req(32'h0000_3004, 1'b0, '0, 32'h0BAD_F00D, 1'b1, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/l2_cache_ctrl.md
L2_CACHE_CTRL -- requirements
Module: l2_cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, number of set-index bits (16 sets).
REQ-002 SHALL have parameter CNT_BITS, default 16, width of the hit and miss counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 addrstb  input  1  L1 request strobe.
REQ-006 addr  input  32  L1 byte address; [2] word select, [2+INDEX_BITS:3] index, [31:3+INDEX_BITS] tag.
REQ-007 we  input  1  1 = L1 write, 0 = L1 read.
REQ-008 wdata  input  32  L1 write data.
REQ-009 rdata  output  32  read data returned to L1.
REQ-010 stall  output  1  request in progress; L1 holds off.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 memreq  output  1  memory transfer request.
REQ-013 memwe  output  1  1 = line writeback, 0 = line fill.
REQ-014 memaddr  output  32  line address; bits [2:0] are always 0.
REQ-015 memwdata  output  64  writeback line data.
REQ-016 memrdata  input  64  fill line data, valid when stb=1.
REQ-017 stb  input  1  memory acknowledge; completes the current transfer.
REQ-018 hitcnt, misscnt  output  CNT_BITS  saturating hit and miss counters.

Function
REQ-019 SHALL implement a direct-mapped, write-back, write-allocate cache with 2^INDEX_BITS lines; each line SHALL hold 64 data bits, a tag, a valid bit and a dirty bit.
REQ-020 SHALL implement the FSM states IDLE, COMPARE, WRITEBACK, FILL and DONE.
REQ-021 IDLE: stall=0; addrstb=1 SHALL latch addr, we and wdata, and the FSM SHALL go to COMPARE; addrstb outside IDLE SHALL be ignored.
REQ-022 COMPARE, WRITEBACK and FILL: stall=1.
REQ-023 COMPARE hit (valid and tag equal), read: rdata SHALL be loaded with the latched word (addr[2]=0 selects bits [31:0], 1 selects [63:32]); the FSM SHALL go to DONE.
REQ-024 COMPARE hit, write: the latched word SHALL be written into the line, dirty SHALL be set to 1 and the FSM SHALL go to DONE.
REQ-025 COMPARE miss with victim valid and dirty: the FSM SHALL go to WRITEBACK.
REQ-026 COMPARE miss otherwise: the FSM SHALL go to FILL.
REQ-027 WRITEBACK: memreq=1, memwe=1, memaddr={victim tag, index, 3'b000}, memwdata=victim line; on stb=1 the FSM SHALL go to FILL.
REQ-028 FILL: memreq=1, memwe=0, memaddr={request tag, index, 3'b000}.
REQ-029 FILL with stb=1: the line SHALL be written with memrdata, tag updated, valid=1, dirty=0, and the FSM SHALL return to COMPARE, which then hits.
REQ-030 All memory-side outputs SHALL be registered; memreq SHALL deassert in the cycle after the stb that ends the last transfer.
REQ-031 DONE: stall=0 and done=1 for exactly one cycle; rdata SHALL be held until the next read completes; the FSM SHALL go to IDLE.
REQ-032 Hit latency SHALL be 3 cycles from the addrstb edge to done (IDLE, COMPARE, DONE).
REQ-033 Miss latency SHALL be hit latency plus the memory wait cycles of each transfer.
REQ-034 hitcnt SHALL increment once per request that hits on its first COMPARE; misscnt SHALL increment once per request that misses on its first COMPARE; the post-fill COMPARE SHALL NOT count.
REQ-035 Both counters SHALL saturate at all-ones.
REQ-036 stb received while memreq=0 SHALL be ignored.
REQ-037 memwdata and memaddr SHALL remain stable while memreq=1.
REQ-038 A request whose index and tag equal the victim's cannot miss; a dirty victim SHALL be written back even if it was never read.

Reset
REQ-039 On reset=1 the FSM SHALL go to IDLE and all valid and dirty bits SHALL clear.
REQ-040 On reset=1 stall, done, memreq, memwe, rdata, memaddr, memwdata, hitcnt and misscnt SHALL reset to 0.
REQ-041 Data and tag arrays need no reset.
REQ-042 Reset during WRITEBACK or FILL SHALL abort the transfer: memreq=0 the next cycle, with no partial line update.
REQ-043 Reset SHALL override a simultaneous addrstb or stb.

Verification
REQ-044 After reset, read 0x0000_0040 with memory returning 0x1111_2222_3333_4444 -> one FILL at memaddr 0x40, no WRITEBACK, rdata=0x3333_4444, misscnt=1.
REQ-045 Then read 0x0000_0044 -> hit, done 3 cycles after addrstb, no memreq, rdata=0x1111_2222, hitcnt=1.
REQ-046 Write 0xDEAD_BEEF to 0x44, then read 0x0000_0840 (same index, new tag) -> WRITEBACK at 0x40 with memwdata=0xDEAD_BEEF_3333_4444, then FILL at 0x840.
REQ-047 Memory delays stb by 5 cycles -> memreq, memaddr and memwdata stay stable and stall stays 1 throughout.
REQ-048 Assert reset two cycles into FILL -> memreq=0 next cycle, state IDLE; a following read of the same address misses.
REQ-049 addrstb pulsed during stall, and stb pulsed in IDLE -> both ignored; counters and state unchanged.
